note_arbiter: RTL and testbench

Two-source note arbiter for the music player. It shares the 8-bit note path between two requesters, such as song playback and manual keypad entry. It steers the existing 2-to-1 8-bit mux to the winning source and holds that note for its requested duration. After each note it inserts a fixed silent gap before the next grant.

---
 rtl/note_arbiter_pkg.sv | 12 +
 rtl/note_arbiter_mux.sv | 11 +
 rtl/note_arbiter.sv | 147 ++++++++++++++
 tb/tb_note_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/note_arbiter_pkg.sv
// Shared types and constants for the two-source note arbiter.
package note_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [7:0] SILENCE = 8'h00;

endpackage

// File: rtl/note_arbiter_mux.sv
// Existing 2-to-1 8-bit note mux; purely combinational.
module Mux2_8b_RTL (
    input  logic [7:0] in0_i,
    input  logic [7:0] in1_i,
    input  logic       sel_i,
    output logic [7:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/note_arbiter.sv
// Two-source note arbiter: grants one requester, plays its note for max(dur,1)
// cycles, then inserts GAP_CYCLES of silence. Define NOTE_ARB_RR_EN for round-robin ties.
module note_arbiter
    import note_arb_pkg::*;
#(
    parameter int DUR_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [7:0]       note0,
    input  logic [DUR_W-1:0] dur0,
    input  logic             req1,
    input  logic [7:0]       note1,
    input  logic [DUR_W-1:0] dur1,
    output logic             ack0,
    output logic             ack1,
    output logic             sel,
    output logic [7:0]       note_out,
    output logic             playing
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    state_e           state_q, state_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       note_q, note_d;
    logic             sel_q, sel_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             win;
    logic [7:0]       mux_note;

    // A zero duration still sounds for one cycle, so the counter never wraps.
    function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

`ifdef NOTE_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        win = (req0 && req1) ? ~last_q : req1;
    end
`else
    always_comb begin
        win = req1 & ~req0;
    end
`endif

    Mux2_8b_RTL u_mux (
        .in0_i (note0),
        .in1_i (note1),
        .sel_i (win),
        .out_o (mux_note)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            note_q  <= SILENCE;
            sel_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
`ifdef NOTE_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            note_q  <= note_d;
            sel_q   <= sel_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
`ifdef NOTE_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        note_d  = note_q;
        sel_d   = sel_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
`ifdef NOTE_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = PLAY;
                    note_d  = mux_note;
                    sel_d   = win;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    cnt_d   = clamp_dur(win ? dur1 : dur0);
`ifdef NOTE_ARB_RR_EN
                    last_d  = win;
`endif
                end
            end
            PLAY: begin
                if (cnt_q <= DUR_W'(1)) begin
                    note_d = SILENCE;
                    cnt_d  = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_W'(GAP_CYCLES);
                    end
                end else begin
                    cnt_d = cnt_q - DUR_W'(1);
                end
            end
            GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ack0     = ack0_q;
        ack1     = ack1_q;
        sel      = sel_q;
        note_out = note_q;
        playing  = (state_q == PLAY);
    end

endmodule

// File: tb/tb_note_arbiter.sv
// Directed bench for note_arbiter; tie expectations follow NOTE_ARB_RR_EN.
module tb_note_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] note0, note1;
    logic [7:0] dur0, dur1;
    logic       ack0, ack1, sel, playing;
    logic [7:0] note_out;

    int total = 0;
    int bad   = 0;

    note_arbiter #(.DUR_W(8), .GAP_CYCLES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .note0    (note0),
        .dur0     (dur0),
        .req1     (req1),
        .note1    (note1),
        .dur1     (dur1),
        .ack0     (ack0),
        .ack1     (ack1),
        .sel      (sel),
        .note_out (note_out),
        .playing  (playing)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic a0, input logic a1, input logic s,
                           input logic [7:0] n, input logic p);
        chk({tag, ".ack0"}, {31'd0, ack0}, {31'd0, a0});
        chk({tag, ".ack1"}, {31'd0, ack1}, {31'd0, a1});
        chk({tag, ".sel"}, {31'd0, sel}, {31'd0, s});
        chk({tag, ".note"}, {24'd0, note_out}, {24'd0, n});
        chk({tag, ".play"}, {31'd0, playing}, {31'd0, p});
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    int exp_cyc[4];
    logic exp_src[4];
    int got_cyc[4];
    logic got_src[4];
    logic [7:0] got_note[4];
    int ng;

    initial begin
        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        note0 = 8'h3C; dur0 = 8'd4;
        note1 = 8'h45; dur1 = 8'd3;

        // Reset held two cycles with both requests high
        tick();
        chk_out("rst_c1", 0, 0, 0, 8'h00, 0);
        tick();
        chk_out("rst_c2", 0, 0, 0, 8'h00, 0);
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        tick();
        chk_out("idle", 0, 0, 0, 8'h00, 0);

        // Single request, dur 4
        req0 = 1'b1; note0 = 8'h3C; dur0 = 8'd4;
        tick();
        chk_out("single_n1", 1, 0, 0, 8'h3C, 1);
        req0 = 1'b0;
        tick();
        chk_out("single_n2", 0, 0, 0, 8'h3C, 1);
        tick();
        chk_out("single_n3", 0, 0, 0, 8'h3C, 1);
        tick();
        chk_out("single_n4", 0, 0, 0, 8'h3C, 1);
        tick();
        chk_out("single_n5", 0, 0, 0, 8'h00, 0);
        tick();
        chk_out("single_n6", 0, 0, 0, 8'h00, 0);
        req0 = 1'b1;
        tick();
        chk_out("single_n7", 0, 0, 0, 8'h00, 0);
        tick();
        chk_out("single_n8", 1, 0, 0, 8'h3C, 1);

        // Tie with both sources requesting continuously
        reset_dut();
        note0 = 8'h40; dur0 = 8'd2;
        note1 = 8'h45; dur1 = 8'd3;
        req0 = 1'b1; req1 = 1'b1;
`ifdef NOTE_ARB_RR_EN
        exp_cyc = '{1, 6, 12, 17};
        exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_cyc = '{1, 6, 11, 16};
        exp_src = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        ng = 0;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if ((ack0 || ack1) && ng < 4) begin
                got_cyc[ng]  = c;
                got_src[ng]  = ack1;
                got_note[ng] = note_out;
                ng++;
            end
        end
        chk("tie_count", ng, 4);
        for (int g = 0; g < 4; g++) begin
            if (g < ng) begin
                chk($sformatf("tie%0d_cyc", g), got_cyc[g], exp_cyc[g]);
                chk($sformatf("tie%0d_src", g), {31'd0, got_src[g]}, {31'd0, exp_src[g]});
                chk($sformatf("tie%0d_note", g), {24'd0, got_note[g]},
                    exp_src[g] ? 32'h45 : 32'h40);
            end
        end

        // Zero duration plays one cycle, then two gap cycles
        reset_dut();
        req1 = 1'b1; note1 = 8'h50; dur1 = 8'd0;
        tick();
        chk_out("zero_n1", 0, 1, 1, 8'h50, 1);
        req1 = 1'b0;
        tick();
        chk_out("zero_n2", 0, 0, 1, 8'h00, 0);
        tick();
        chk_out("zero_n3", 0, 0, 1, 8'h00, 0);
        req1 = 1'b1;
        tick();
        chk_out("zero_n4", 0, 0, 1, 8'h00, 0);
        tick();
        chk_out("zero_n5", 0, 1, 1, 8'h50, 1);

        // Request from source 1 arriving mid-note waits for IDLE
        reset_dut();
        req0 = 1'b1; note0 = 8'h3C; dur0 = 8'd4;
        tick();
        chk_out("mid_n1", 1, 0, 0, 8'h3C, 1);
        req0 = 1'b0;
        req1 = 1'b1; note1 = 8'h45; dur1 = 8'd1;
        for (int c = 2; c <= 7; c++) begin
            tick();
            chk($sformatf("mid_n%0d_ack1", c), {31'd0, ack1}, 32'd0);
        end
        tick();
        chk_out("mid_n8", 0, 1, 1, 8'h45, 1);

        // Reset in cycle 2 of a dur 5 note, then a tie
        reset_dut();
        req1 = 1'b0;
        req0 = 1'b1; note0 = 8'h3C; dur0 = 8'd5;
        tick();
        chk_out("rmid_n1", 1, 0, 0, 8'h3C, 1);
        req0 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk_out("rmid_n3", 0, 0, 0, 8'h00, 0);
        reset = 1'b0;
        req0 = 1'b1; note0 = 8'h40; dur0 = 8'd2;
        req1 = 1'b1; note1 = 8'h45; dur1 = 8'd3;
        tick();
        chk_out("rmid_tie", 1, 0, 0, 8'h40, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
